// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the quadrature encoder counter:
//   - decode mode encodings (x1 / x2 / x4)
//   - Gray-code forward sequence 00 -> 10 -> 11 -> 01 -> 00, bit 1 = A, bit 0 = B
//   - signed step type carrying -1 / 0 / +1
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package enc_pkg;

    localparam logic [1:0] ENC_X1 = 2'b00;
    localparam logic [1:0] ENC_X2 = 2'b01;
    localparam logic [1:0] ENC_X4 = 2'b10;   // 2'b11 also decodes as x4

    // Forward (clockwise) Gray sequence, state = {A, B}
    localparam logic [1:0] GRAY_S0 = 2'b00;
    localparam logic [1:0] GRAY_S1 = 2'b10;
    localparam logic [1:0] GRAY_S2 = 2'b11;
    localparam logic [1:0] GRAY_S3 = 2'b01;

    typedef logic signed [1:0] step_t;

    localparam step_t STEP_NONE = 2'sb00;
    localparam step_t STEP_FWD  = 2'sb01;
    localparam step_t STEP_REV  = 2'sb11;

    // State that follows s when rotating forward
    function automatic logic [1:0] gray_fwd_next(input logic [1:0] s);
        case (s)
            GRAY_S0: return GRAY_S1;
            GRAY_S1: return GRAY_S2;
            GRAY_S2: return GRAY_S3;
            default: return GRAY_S0;
        endcase
    endfunction

endpackage

// File: rtl/enc_debounce.sv
// ---------------------------------------------------------------------------
// enc_debounce
// One encoder phase: 2-FF synchroniser followed by a sample-history filter.
// The synced level is shifted into a DEB_SAMPLES-deep history on each tick;
// the filtered level only moves when the whole history agrees.
// Ports:
//   clk     : system clock
//   rst     : synchronous active-high reset (all state -> RESET_LVL)
//   i_raw   : asynchronous raw pin
//   i_tick  : one-clk sample strobe from the shared prescaler
//   o_level : filtered level
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module enc_debounce
    import enc_pkg::*;
#(
    parameter int   DEB_SAMPLES = 2,
    parameter logic RESET_LVL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_level
);

    logic [1:0]             r_sync;
    logic [DEB_SAMPLES-1:0] r_hist;
    logic                   r_level;
    logic [DEB_SAMPLES-1:0] w_hist_next;

    // History including the sample taken on this tick; the decision uses it
    // so the level can move on the very tick that completes the run.
    assign w_hist_next = {r_hist[DEB_SAMPLES-2:0], r_sync[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= {2{RESET_LVL}};
            r_hist  <= {DEB_SAMPLES{RESET_LVL}};
            r_level <= RESET_LVL;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (i_tick) begin
                r_hist <= w_hist_next;
                if (&w_hist_next) begin
                    r_level <= 1'b1;
                end else if (~|w_hist_next) begin
                    r_level <= 1'b0;
                end
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/quad_encoder_counter.sv
// ---------------------------------------------------------------------------
// quad_encoder_counter
// Debounced quadrature decoder with detent accumulation and a bounded
// position counter (saturating or wrapping), parallel load and
// illegal-transition flagging.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   enc_a, enc_b      : raw encoder phases (async, idle high)
//   mode              : 00 x1, 01 x2, 1x x4
//   load_en, load_val : load strobe and value (clamped to the bounds)
//   position          : current position
//   cw, ccw           : one-clk pulse per reported step
//   dir               : sticky direction of last reported step (1 = cw)
//   at_min, at_max    : position sits on a bound
//   err               : one-clk pulse when both phases change together
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module quad_encoder_counter
    import enc_pkg::*;
#(
    parameter int CNT_W            = 6,
    parameter int CNT_MIN          = 0,
    parameter int CNT_MAX          = 36,
    parameter int CNT_INIT         = 18,
    parameter int DEB_DIV          = 100000,
    parameter int DEB_SAMPLES      = 2,
    parameter int STEPS_PER_DETENT = 1,
    parameter int WRAP             = 0,
    parameter int INVERT           = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic [1:0]       mode,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] position,
    output logic             cw,
    output logic             ccw,
    output logic             dir,
    output logic             at_min,
    output logic             at_max,
    output logic             err
);

    localparam int PRE_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DEB_DIV - 1);
    localparam int ACC_W = 4;   // holds -4..+4
    localparam logic signed [ACC_W-1:0] SPD_P = ACC_W'(STEPS_PER_DETENT);
    localparam logic signed [ACC_W-1:0] SPD_N = -SPD_P;
    localparam logic [CNT_W-1:0] L_MIN  = CNT_W'(CNT_MIN);
    localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] L_INIT = CNT_W'(CNT_INIT);
    localparam logic [CNT_W:0]   L_MAX1 = (CNT_W+1)'(CNT_MAX);

    logic [PRE_W-1:0]        r_presc;
    logic [1:0]              r_prev_ab;
    logic [1:0]              r_mode_prev;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_pos;
    logic                    r_cw, r_ccw, r_err, r_dir;

    logic                    w_tick;
    logic [1:0]              w_raw;
    logic [1:0]              w_ab;
    logic [1:0]              w_changed;
    logic                    w_fwd;
    logic                    w_mode_chg;
    step_t                   w_step_raw, w_step;
    logic signed [ACC_W-1:0] w_acc_base, w_acc_sum, w_acc_next;
    logic                    w_cw_next, w_ccw_next, w_dir_next;
    logic [CNT_W:0]          w_pos_inc, w_pos_dec;
    logic [CNT_W-1:0]        w_load_clamped, w_pos_next;

    // ---------------- debounce tick and per-phase filters -----------------
    assign w_tick = (r_presc == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_raw = {enc_a, enc_b};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_phase
            enc_debounce #(
                .DEB_SAMPLES (DEB_SAMPLES),
                .RESET_LVL   (1'b1)
            ) u_deb (
                .clk     (clk),
                .rst     (rst),
                .i_raw   (w_raw[gi]),
                .i_tick  (w_tick),
                .o_level (w_ab[gi])
            );
        end
    endgenerate

    // ---------------- Gray decode ----------------
    assign w_changed  = w_ab ^ r_prev_ab;
    assign w_fwd      = (w_ab == gray_fwd_next(r_prev_ab));
    assign w_mode_chg = (mode != r_mode_prev);

    always_comb begin
        w_step_raw = STEP_NONE;
        // Only single-bit changes are legal steps
        if (w_changed == 2'b01 || w_changed == 2'b10) begin
            case (mode)
                ENC_X1: begin
                    if (r_prev_ab[1] && !w_ab[1]) begin
                        w_step_raw = w_ab[0] ? STEP_FWD : STEP_REV;
                    end
                end
                ENC_X2: begin
                    if (w_changed[1]) begin
                        w_step_raw = w_fwd ? STEP_FWD : STEP_REV;
                    end
                end
                default: begin
                    w_step_raw = w_fwd ? STEP_FWD : STEP_REV;
                end
            endcase
        end
        w_step = (INVERT != 0) ? step_t'(-w_step_raw) : w_step_raw;
    end

    // ---------------- detent accumulator ----------------
    // A reversal (or a mode change) restarts the count from zero before the
    // new step is added.
    assign w_acc_base = (w_mode_chg || (r_acc != '0 && (r_acc[ACC_W-1] != w_step[1])))
                        ? '0 : r_acc;
    assign w_acc_sum  = w_acc_base + ACC_W'(w_step);

    always_comb begin
        w_acc_next = w_mode_chg ? '0 : r_acc;
        w_cw_next  = 1'b0;
        w_ccw_next = 1'b0;
        if (load_en) begin
            w_acc_next = '0;            // simultaneous step is dropped
        end else if (w_step != STEP_NONE) begin
            if (w_acc_sum == SPD_P) begin
                w_cw_next  = 1'b1;
                w_acc_next = '0;
            end else if (w_acc_sum == SPD_N) begin
                w_ccw_next = 1'b1;
                w_acc_next = '0;
            end else begin
                w_acc_next = w_acc_sum;
            end
        end
    end

    // ---------------- position counter ----------------
    assign w_pos_inc = {1'b0, r_pos} + 1'b1;
    assign w_pos_dec = {1'b0, r_pos} - 1'b1;

    always_comb begin
        if (int'(load_val) < CNT_MIN) begin
            w_load_clamped = L_MIN;
        end else if ({1'b0, load_val} > L_MAX1) begin
            w_load_clamped = L_MAX;
        end else begin
            w_load_clamped = load_val;
        end
    end

    always_comb begin
        w_pos_next = r_pos;
        w_dir_next = r_dir;
        if (load_en) begin
            w_pos_next = w_load_clamped;
        end else if (w_cw_next) begin
            w_dir_next = 1'b1;
            if (w_pos_inc > L_MAX1) begin
                w_pos_next = (WRAP != 0) ? L_MIN : L_MAX;
            end else begin
                w_pos_next = w_pos_inc[CNT_W-1:0];
            end
        end else if (w_ccw_next) begin
            w_dir_next = 1'b0;
            if (r_pos == L_MIN) begin
                w_pos_next = (WRAP != 0) ? L_MAX : L_MIN;
            end else begin
                w_pos_next = w_pos_dec[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_ab   <= 2'b11;
            r_mode_prev <= mode;
            r_acc       <= '0;
            r_pos       <= L_INIT;
            r_cw        <= 1'b0;
            r_ccw       <= 1'b0;
            r_err       <= 1'b0;
            r_dir       <= 1'b1;
        end else begin
            r_prev_ab   <= w_ab;
            r_mode_prev <= mode;
            r_acc       <= w_acc_next;
            r_pos       <= w_pos_next;
            r_cw        <= w_cw_next;
            r_ccw       <= w_ccw_next;
            r_err       <= &w_changed;
            r_dir       <= w_dir_next;
        end
    end

    assign position = r_pos;
    assign cw       = r_cw;
    assign ccw      = r_ccw;
    assign dir      = r_dir;
    assign err      = r_err;
    assign at_min   = (r_pos == L_MIN);
    assign at_max   = (r_pos == L_MAX);

endmodule

// File: tb/tb_quad_encoder_counter.sv
`timescale 1ns/1ps
module tb_quad_encoder_counter;

    localparam int HOLD = 24;   // clks per encoder state; covers 2 clk + 2 ticks + decode
    localparam logic [2:0] K_CW  = 3'b001;
    localparam logic [2:0] K_CCW = 3'b010;
    localparam logic [2:0] K_ERR = 3'b100;

    typedef struct {
        int         d;
        logic [2:0] kind;
        logic [5:0] pos;
        logic       dir;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       enc_a [3];
    logic       enc_b [3];
    logic [1:0] mode [3];
    logic       load_en [3];
    logic [5:0] load_val [3];
    logic [5:0] position [3];
    logic       cw [3];
    logic       ccw [3];
    logic       dir [3];
    logic       at_min [3];
    logic       at_max [3];
    logic       err [3];

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // dut0: x1/x2 saturating, 1 step per detent
    quad_encoder_counter #(.CNT_W(6), .CNT_MIN(0), .CNT_MAX(36), .CNT_INIT(18),
        .DEB_DIV(4), .DEB_SAMPLES(2), .STEPS_PER_DETENT(1), .WRAP(0), .INVERT(0)) u_dut0 (
        .clk(clk), .rst(rst), .enc_a(enc_a[0]), .enc_b(enc_b[0]), .mode(mode[0]),
        .load_en(load_en[0]), .load_val(load_val[0]), .position(position[0]),
        .cw(cw[0]), .ccw(ccw[0]), .dir(dir[0]), .at_min(at_min[0]),
        .at_max(at_max[0]), .err(err[0]));

    // dut1: x4, 4 quarter-steps per detent
    quad_encoder_counter #(.CNT_W(6), .CNT_MIN(0), .CNT_MAX(36), .CNT_INIT(18),
        .DEB_DIV(4), .DEB_SAMPLES(2), .STEPS_PER_DETENT(4), .WRAP(0), .INVERT(0)) u_dut1 (
        .clk(clk), .rst(rst), .enc_a(enc_a[1]), .enc_b(enc_b[1]), .mode(mode[1]),
        .load_en(load_en[1]), .load_val(load_val[1]), .position(position[1]),
        .cw(cw[1]), .ccw(ccw[1]), .dir(dir[1]), .at_min(at_min[1]),
        .at_max(at_max[1]), .err(err[1]));

    // dut2: x1, wrapping, inverted sense
    quad_encoder_counter #(.CNT_W(6), .CNT_MIN(0), .CNT_MAX(36), .CNT_INIT(18),
        .DEB_DIV(4), .DEB_SAMPLES(2), .STEPS_PER_DETENT(1), .WRAP(1), .INVERT(1)) u_dut2 (
        .clk(clk), .rst(rst), .enc_a(enc_a[2]), .enc_b(enc_b[2]), .mode(mode[2]),
        .load_en(load_en[2]), .load_val(load_val[2]), .position(position[2]),
        .cw(cw[2]), .ccw(ccw[2]), .dir(dir[2]), .at_min(at_min[2]),
        .at_max(at_max[2]), .err(err[2]));

    task automatic expect_evt(input int d, input logic [2:0] k, input logic [5:0] p,
                              input logic dr);
        exp_t e;
        e.d = d; e.kind = k; e.pos = p; e.dir = dr;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    task automatic move(input int d, input logic a, input logic b);
        @(negedge clk);
        enc_a[d] = a;
        enc_b[d] = b;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic load(input int d, input logic [5:0] v);
        @(negedge clk);
        load_val[d] = v;
        load_en[d]  = 1'b1;
        @(negedge clk);
        load_en[d]  = 1'b0;
    endtask

    // Forward cycle from 11: 11->01->00->10->11; x1 steps on 11->01.
    task automatic fwd_cycle_x1(input int d, input logic [2:0] k, input logic [5:0] p,
                                input logic dr);
        expect_evt(d, k, p, dr);
        move(d, 1'b0, 1'b1);
        move(d, 1'b0, 1'b0);
        move(d, 1'b1, 1'b0);
        move(d, 1'b1, 1'b1);
    endtask

    // Reverse cycle from 11: 11->10->00->01->11; x1 steps on 10->00.
    task automatic rev_cycle_x1(input int d, input logic [2:0] k, input logic [5:0] p,
                                input logic dr);
        move(d, 1'b1, 1'b0);
        expect_evt(d, k, p, dr);
        move(d, 1'b0, 1'b0);
        move(d, 1'b0, 1'b1);
        move(d, 1'b1, 1'b1);
    endtask

    // Monitor: every cw/ccw/err pulse must match the next queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (cw[d] || ccw[d] || err[d]) begin
                    exp_t e;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_event dut%0d: got kind=%b pos=%0d, required no event",
                                 d, {err[d], ccw[d], cw[d]}, position[d]);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.d != d || e.kind !== {err[d], ccw[d], cw[d]} ||
                            e.pos !== position[d] || e.dir !== dir[d]) begin
                            n_bad++;
                            $display("FAIL event dut%0d: got kind=%b pos=%0d dir=%b, required dut%0d kind=%b pos=%0d dir=%b",
                                     d, {err[d], ccw[d], cw[d]}, position[d], dir[d],
                                     e.d, e.kind, e.pos, e.dir);
                        end else begin
                            $display("ok   event dut%0d kind=%b pos=%0d dir=%b",
                                     d, e.kind, e.pos, e.dir);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            enc_a[d] = 1'b1; enc_b[d] = 1'b1;
            load_en[d] = 1'b0; load_val[d] = 6'd0;
            mode[d] = 2'b00;
        end
        mode[1] = 2'b10;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_pos0", position[0], 18);
        chk("rst_cw0", cw[0], 0);
        chk("rst_ccw0", ccw[0], 0);
        chk("rst_err0", err[0], 0);
        chk("rst_dir0", dir[0], 1);
        chk("rst_atmin0", at_min[0], 0);
        chk("rst_atmax0", at_max[0], 0);
        chk("rst_pos1", position[1], 18);
        chk("rst_pos2", position[2], 18);
        rst = 1'b0;
        repeat (HOLD) @(negedge clk);

        // x1: three forward cycles -> 19, 20, 21
        for (int i = 0; i < 3; i++) fwd_cycle_x1(0, K_CW, 6'(19 + i), 1'b1);
        chk("x1_pos", position[0], 21);
        chk("x1_dir", dir[0], 1);

        // x2: one forward cycle -> two steps
        @(negedge clk); mode[0] = 2'b01;
        expect_evt(0, K_CW, 6'd22, 1'b1);
        move(0, 1'b0, 1'b1);
        move(0, 1'b0, 1'b0);
        expect_evt(0, K_CW, 6'd23, 1'b1);
        move(0, 1'b1, 1'b0);
        move(0, 1'b1, 1'b1);
        chk("x2_pos", position[0], 23);
        @(negedge clk); mode[0] = 2'b00;

        // Saturate at max
        load(0, 6'd35);
        chk("load35_pos", position[0], 35);
        for (int i = 0; i < 3; i++) fwd_cycle_x1(0, K_CW, 6'd36, 1'b1);
        chk("sat_max_pos", position[0], 36);
        chk("sat_at_max", at_max[0], 1);

        // Saturate at min
        load(0, 6'd0);
        chk("load0_at_min", at_min[0], 1);
        rev_cycle_x1(0, K_CCW, 6'd0, 1'b0);
        chk("sat_min_pos", position[0], 0);
        chk("sat_min_dir", dir[0], 0);

        // One-clk glitch on A: filtered out
        @(negedge clk); enc_a[0] = 1'b0;
        @(negedge clk); enc_a[0] = 1'b1;
        repeat (HOLD) @(negedge clk);
        chk("glitch_pos", position[0], 0);

        // Illegal 00->11 jump -> err, no step
        expect_evt(0, K_CW, 6'd1, 1'b1);
        move(0, 1'b0, 1'b1);
        move(0, 1'b0, 1'b0);
        expect_evt(0, K_ERR, 6'd1, 1'b1);
        move(0, 1'b1, 1'b1);
        chk("err_pos", position[0], 1);

        // Load held across a step: step dropped, value clamped
        load(0, 6'd10);
        chk("load10_pos", position[0], 10);
        @(negedge clk);
        load_val[0] = 6'd50;
        load_en[0]  = 1'b1;
        enc_a[0]    = 1'b0;
        repeat (HOLD) @(negedge clk);
        load_en[0]  = 1'b0;
        chk("load_clamp_pos", position[0], 36);
        move(0, 1'b0, 1'b0);
        move(0, 1'b1, 1'b0);
        move(0, 1'b1, 1'b1);

        // x4, 4 per detent: 6 forward then 2 reverse
        move(1, 1'b0, 1'b1);
        move(1, 1'b0, 1'b0);
        move(1, 1'b1, 1'b0);
        expect_evt(1, K_CW, 6'd19, 1'b1);
        move(1, 1'b1, 1'b1);
        move(1, 1'b0, 1'b1);
        move(1, 1'b0, 1'b0);
        move(1, 1'b0, 1'b1);
        move(1, 1'b1, 1'b1);
        chk("x4_pos", position[1], 19);

        // Inverted, wrapping build
        fwd_cycle_x1(2, K_CCW, 6'd17, 1'b0);
        fwd_cycle_x1(2, K_CCW, 6'd16, 1'b0);
        chk("inv_pos", position[2], 16);
        load(2, 6'd0);
        fwd_cycle_x1(2, K_CCW, 6'd36, 1'b0);
        chk("wrap_min_at_max", at_max[2], 1);
        rev_cycle_x1(2, K_CW, 6'd0, 1'b1);
        chk("wrap_max_pos", position[2], 0);

        // Reset with a partial detent of 2 pending on dut1
        move(1, 1'b0, 1'b1);
        move(1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        enc_a[1] = 1'b1; enc_b[1] = 1'b1;
        @(negedge clk);
        chk("rst2_pos1", position[1], 18);
        chk("rst2_cw1", cw[1], 0);
        chk("rst2_dir1", dir[1], 1);
        chk("rst2_pos0", position[0], 18);
        chk("rst2_pos2", position[2], 18);
        rst = 1'b0;
        repeat (HOLD) @(negedge clk);
        move(1, 1'b0, 1'b1);
        move(1, 1'b0, 1'b0);
        move(1, 1'b1, 1'b0);
        expect_evt(1, K_CW, 6'd19, 1'b1);
        move(1, 1'b1, 1'b1);
        chk("post_rst_pos1", position[1], 19);

        repeat (HOLD) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/quad_encoder_counter.md
Name: quad_encoder_counter

Overview:
- Parametrised successor to the single-channel EC11 rotary reader.
- Per channel: input sync and debounce, Gray-code quadrature decode in x1/x2/x4 mode, detent accumulation, and a bounded position counter.
- Counter runs in saturate or wrap mode and supports a parallel load, illegal-transition detection and direction inversion.
- Sits between the front-panel encoder pins and the control/UI logic, which consumes the position value and the step pulses.

Parameters:
- CNT_W, 6: position counter width in bits.
- CNT_MIN, 0: lower bound of the position.
- CNT_MAX, 36: upper bound of the position.
- CNT_INIT, 18: position value after reset.
- DEB_DIV, 100000: clk cycles per debounce sample tick (1 ms at 100 MHz).
- DEB_SAMPLES, 2: consecutive equal samples required before the filtered level changes (range 2..8).
- STEPS_PER_DETENT, 1: decoded quarter/half steps per reported step (range 1..4).
- WRAP, 0: 0 = saturate at bounds, 1 = wrap CNT_MAX<->CNT_MIN.
- INVERT, 0: 1 swaps the cw/ccw sense.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- enc_a, in, 1: raw encoder A, asynchronous, idle high.
- enc_b, in, 1: raw encoder B, asynchronous, idle high.
- mode, in, 2: 00 = x1 (A falling edge only), 01 = x2 (any A edge), 10/11 = x4 (every valid transition).
- load_en, in, 1: one-cycle load strobe.
- load_val, in, CNT_W: value to load, clamped to [CNT_MIN, CNT_MAX].
- position, out, CNT_W: current position.
- cw, out, 1: one-cycle pulse per reported clockwise step.
- ccw, out, 1: one-cycle pulse per reported counter-clockwise step.
- dir, out, 1: sticky direction of the last reported step; 1 = cw.
- at_min, out, 1: position == CNT_MIN.
- at_max, out, 1: position == CNT_MAX.
- err, out, 1: one-cycle pulse on an illegal transition (both phases changed in one debounced update).

Behaviour:
- Reset (rst=1 at a clk edge):
  - position=CNT_INIT; cw=ccw=err=0; dir=1.
  - at_min/at_max reflect CNT_INIT.
  - Sync flops, debounced levels and previous AB state all = 1.
  - Prescaler = 0; detent accumulator = 0.
  - Reset mid-rotation discards partial steps.
- Sync and debounce:
  - enc_a/enc_b pass through 2-FF synchronisers every clk.
  - Prescaler counts 0..DEB_DIV-1; tick is asserted for one clk when the count equals DEB_DIV-1, then the count returns to 0.
  - On each tick, the synced level shifts into a DEB_SAMPLES-deep history.
  - The filtered level takes the new value only when the whole history is equal; otherwise it holds.
- Decode: compare the filtered state {A,B} with the previous state each clk, then update the previous state.
  - Forward (cw) sequence: 00->10->11->01->00. Reverse is the opposite order.
  - x4: every valid transition gives +-1.
  - x2: only transitions where A changes.
  - x1: only A 1->0. B=1 gives +1; B=0 gives -1.
  - Both bits changed: err pulse, no step, previous state still updates.
  - INVERT negates the step sign.
- Detent accumulation:
  - Signed accumulator adds each step.
  - Reaching +STEPS_PER_DETENT gives cw=1 and the accumulator clears.
  - Reaching -STEPS_PER_DETENT gives ccw=1 and the accumulator clears.
  - A step opposite in sign to a nonzero accumulator first clears the accumulator and then adds the step (direction reversal restarts the detent count).
  - Any change of mode clears the accumulator.
- Counter (same clk as the cw/ccw pulse, so position updates 1 clk after the decoded transition):
  - cw: position+1; ccw: position-1.
  - At a bound with WRAP=0: position holds; cw/ccw still pulse; dir still updates.
  - At a bound with WRAP=1: CNT_MAX+1 -> CNT_MIN and CNT_MIN-1 -> CNT_MAX.
  - load_en wins over a simultaneous step: that step is dropped and the accumulator clears.
  - Loaded values are clamped to the bounds.
- Latency: from a stable raw edge, the filtered level changes after at most 2 clk + DEB_SAMPLES ticks; cw/ccw and position follow 1 clk later.
- Bounds: position never leaves [CNT_MIN, CNT_MAX]. Arithmetic uses CNT_W+1 bits before the clamp or wrap.

Decomposition:
- Shared package enc_pkg:
  - mode encodings ENC_X1, ENC_X2, ENC_X4;
  - Gray forward-transition constants;
  - step sign type (2-bit signed: -1/0/+1).
- Sub-module enc_debounce (parameters DEB_SAMPLES, RESET_LVL): 2-FF sync plus history filter, driven by the shared tick. It is instantiated twice; the prescaler stays in the top.

Test Plan (DEB_DIV=4, DEB_SAMPLES=2, CNT_W=6, range 0..36, init 18 unless noted):
- Reset, then x1 mode, 3 forward Gray cycles -> 3 cw pulses, position=21, dir=1, err never set.
- x4 mode, STEPS_PER_DETENT=4, 6 forward quarter-steps then 2 reverse -> 1 cw pulse (position 19); the reversal restarts the detent count, so there is no further pulse and position stays 19.
- Saturate: load 35, then 3 forward detents (x1) -> positions 36, 36, 36, at_max=1, 3 cw pulses. WRAP=1 build: load 0, 1 reverse detent -> position=36.
- Glitch 1 clk wide on enc_a (shorter than a tick) -> no filtered change, no pulse, position unchanged. Force AB 00->11 in one tick -> single err pulse, position unchanged.
- load_en with load_val=50 on the same clk as a cw pulse -> position=36, step dropped. INVERT=1 build: forward rotation -> ccw pulses, position decreasing.
- rst asserted mid-sequence (accumulator = 2 in x4, detent 4) -> all outputs at reset values next clk; a following full forward detent yields exactly 1 cw.
